// File: rtl/sdram_scheduler.sv
// sdram_scheduler: top-level sequencer for the SDRAM pin set.
// Runs power-up init once, then arbitrates periodic refresh and host
// read/write requests, granting the shared DRAM bus to exactly one engine
// through the one-hot enb vector {rd, wr, ref, init}.
// Optional feature: define SDRAM_SCHED_WATCHDOG_EN to add a per-grant
// watchdog that aborts a grant after TIMEOUT cycles and flags err.
module sdram_scheduler #(
  parameter int unsigned REF_PERIOD = 390,
  parameter int unsigned REF_W      = 9,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic       iclk,
  input  logic       ctr_reset,
  input  logic       host_rd_req,
  input  logic       host_wr_req,
  output logic       host_rd_ack,
  output logic       host_wr_ack,
  output logic       init_req,
  output logic       ref_req,
  output logic       wr_req,
  output logic       rd_req,
  input  logic       init_fin,
  input  logic       ref_fin,
  input  logic       wr_fin,
  input  logic       rd_fin,
  output logic [3:0] enb,
  output logic       ready,
  output logic       ref_overrun,
  output logic       err
);

  localparam logic [2:0] S_INIT_GO   = 3'd0;
  localparam logic [2:0] S_INIT_WAIT = 3'd1;
  localparam logic [2:0] S_IDLE      = 3'd2;
  localparam logic [2:0] S_GAP       = 3'd3;
  localparam logic [2:0] S_GRANT_REF = 3'd4;
  localparam logic [2:0] S_GRANT_WR  = 3'd5;
  localparam logic [2:0] S_GRANT_RD  = 3'd6;

  localparam logic [3:0] ENB_NONE = 4'b0000;
  localparam logic [3:0] ENB_INIT = 4'b0001;
  localparam logic [3:0] ENB_REF  = 4'b0010;
  localparam logic [3:0] ENB_WR   = 4'b0100;
  localparam logic [3:0] ENB_RD   = 4'b1000;

  // Parameter sanity: refresh counter must hold REF_PERIOD-1
  if (REF_PERIOD < 2 || (2 ** REF_W) <= REF_PERIOD || TIMEOUT < 2) begin : g_param_chk
    $error("sdram_scheduler: inconsistent REF_PERIOD/REF_W/TIMEOUT");
  end

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [3:0]       enb_nxt;
  logic             init_req_nxt;
  logic             ref_req_nxt;
  logic             wr_req_nxt;
  logic             rd_req_nxt;
  logic             host_rd_ack_nxt;
  logic             host_wr_ack_nxt;
  logic             ready_nxt;
  logic             last_wr;
  logic             last_wr_nxt;
  logic             ref_clr;
  logic             err_set;
  logic             granted_fin;
  logic             wd_expired;
  logic [REF_W-1:0] ref_cnt;
  logic             ref_pending;
  logic             ref_tick;

  // fin is honoured only from the engine currently holding the bus
  assign granted_fin = ((state == S_GRANT_REF) && ref_fin) ||
                       ((state == S_GRANT_WR)  && wr_fin)  ||
                       ((state == S_GRANT_RD)  && rd_fin);

`ifdef SDRAM_SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT) + 1;
  logic [WD_W-1:0] wd_cnt;

  // Cycles spent in the current state; restarts on every state change (grant entry)
  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      wd_cnt <= '0;
    end else if (state_nxt != state) begin
      wd_cnt <= '0;
    end else if (!wd_expired) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
`else
  assign wd_expired = 1'b0;
`endif

  // Refresh interval timer; only runs once init has completed
  assign ref_tick = ready && (ref_cnt == REF_W'(REF_PERIOD - 1));

  // Refresh timer, pending flag and sticky overrun; a new tick wins over a same-edge grant
  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
      ref_overrun <= 1'b0;
    end else begin
      if (ready) begin
        ref_cnt <= ref_tick ? '0 : ref_cnt + REF_W'(1);
      end
      if (ref_tick) begin
        ref_pending <= 1'b1;
      end else if (ref_clr) begin
        ref_pending <= 1'b0;
      end
      if (ref_tick && ref_pending) begin
        ref_overrun <= 1'b1;
      end
    end
  end

  // Next-state and next-output decode; outputs reflect the state being entered
  always_comb begin
    state_nxt       = state;
    enb_nxt         = enb;
    init_req_nxt    = 1'b0;
    ref_req_nxt     = 1'b0;
    wr_req_nxt      = 1'b0;
    rd_req_nxt      = 1'b0;
    host_rd_ack_nxt = 1'b0;
    host_wr_ack_nxt = 1'b0;
    ready_nxt       = ready;
    last_wr_nxt     = last_wr;
    ref_clr         = 1'b0;
    err_set         = 1'b0;
    case (state)
      S_INIT_GO: begin
        state_nxt    = S_INIT_WAIT;
        enb_nxt      = ENB_INIT;
        init_req_nxt = 1'b1;
      end
      S_INIT_WAIT: begin
        if (init_fin) begin
          state_nxt = S_IDLE;
          enb_nxt   = ENB_NONE;
          ready_nxt = 1'b1;
        end else if (wd_expired) begin
          state_nxt = S_INIT_GO;
          enb_nxt   = ENB_NONE;
          err_set   = 1'b1;
        end
      end
      S_IDLE: begin
        if (ref_pending) begin
          state_nxt   = S_GRANT_REF;
          enb_nxt     = ENB_REF;
          ref_req_nxt = 1'b1;
          ref_clr     = 1'b1;
        end else if (host_wr_req && (!host_rd_req || !last_wr)) begin
          state_nxt   = S_GRANT_WR;
          enb_nxt     = ENB_WR;
          wr_req_nxt  = 1'b1;
          last_wr_nxt = 1'b1;
        end else if (host_rd_req) begin
          state_nxt   = S_GRANT_RD;
          enb_nxt     = ENB_RD;
          rd_req_nxt  = 1'b1;
          last_wr_nxt = 1'b0;
        end
      end
      S_GAP: begin
        state_nxt = S_IDLE;
      end
      S_GRANT_REF, S_GRANT_WR, S_GRANT_RD: begin
        if (granted_fin) begin
          state_nxt       = S_GAP;
          enb_nxt         = ENB_NONE;
          host_wr_ack_nxt = (state == S_GRANT_WR);
          host_rd_ack_nxt = (state == S_GRANT_RD);
        end else if (wd_expired) begin
          state_nxt = S_GAP;
          enb_nxt   = ENB_NONE;
          err_set   = 1'b1;
        end
      end
      default: begin
        state_nxt = S_INIT_GO;
        enb_nxt   = ENB_NONE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      state       <= S_INIT_GO;
      enb         <= ENB_NONE;
      init_req    <= 1'b0;
      ref_req     <= 1'b0;
      wr_req      <= 1'b0;
      rd_req      <= 1'b0;
      host_rd_ack <= 1'b0;
      host_wr_ack <= 1'b0;
      ready       <= 1'b0;
      last_wr     <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      enb         <= enb_nxt;
      init_req    <= init_req_nxt;
      ref_req     <= ref_req_nxt;
      wr_req      <= wr_req_nxt;
      rd_req      <= rd_req_nxt;
      host_rd_ack <= host_rd_ack_nxt;
      host_wr_ack <= host_wr_ack_nxt;
      ready       <= ready_nxt;
      last_wr     <= last_wr_nxt;
      err         <= err | err_set;
    end
  end

endmodule
